// File: rtl/apb_booth_mac_slave_if.sv
// APB3 bus bundle between a bus master and the Booth MAC slave.
interface apb_booth_mac_slave_if;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_booth_mac_slave.sv
// APB3 register front-end for a Booth multiplier core: holds operands, launches multiplies and
// accumulates signed products into a wrapping MAC register with sticky overflow.
module apb_booth_mac_slave #(
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned ACC_WIDTH     = 32,
  parameter logic [31:0] SLAVE_BASE    = 32'h0000_0000
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  apb_booth_mac_slave_if.slave       apb,
  output logic                       mul_start,
  output logic [OPERAND_WIDTH-1:0]   mul_a,
  output logic [OPERAND_WIDTH-1:0]   mul_b,
  input  logic                       BOOTH_READY,
  input  logic [2*OPERAND_WIDTH-1:0] BOOTH_OUTPUT
);

  localparam int unsigned PW = 2 * OPERAND_WIDTH;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StAccum} state_e;

  state_e                        state_q;
  logic [OPERAND_WIDTH-1:0]      opa_q, opb_q;
  logic                          acc_en_q, done_q, ovf_q;
  logic signed [PW-1:0]          product_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;

  logic [31:0] offset;
  logic [2:0]  idx;
  logic        access, busy, mapped, err, wr_ok;
  logic        wr_opa, wr_opb, wr_ctrl, wr_status, start, acc_clr;
  logic [31:0] rdata;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc_base, acc_sum;
  logic        ovf_now;
  logic        unused_wdata;

  assign unused_wdata = ^apb.PWDATA;

  always_comb begin
    offset = apb.PADDR - SLAVE_BASE;
    idx    = offset[4:2];
    access = apb.PSELx & apb.PENABLE;
    busy   = (state_q != StIdle);
    mapped = (offset[1:0] == 2'b00) && (offset[31:5] == 27'd0) && (idx <= 3'd5);
    err    = ~mapped;
    if (apb.PWRITE && mapped) begin
      case (idx)
        3'd0, 3'd1: err = busy;
        3'd2:       err = busy & apb.PWDATA[0];
        3'd4, 3'd5: err = 1'b1;
        default:    err = 1'b0;
      endcase
    end
    wr_ok     = access & apb.PWRITE & ~err;
    wr_opa    = wr_ok & (idx == 3'd0);
    wr_opb    = wr_ok & (idx == 3'd1);
    wr_ctrl   = wr_ok & (idx == 3'd2);
    wr_status = wr_ok & (idx == 3'd3);
    start     = wr_ctrl & apb.PWDATA[0];
    acc_clr   = wr_ctrl & apb.PWDATA[1];
  end

  // A clear landing in the ACCUM cycle is applied first; the product then adds onto zero.
  always_comb begin
    prod_ext = ACC_WIDTH'(product_q);
    acc_base = (acc_clr || !acc_en_q) ? '0 : acc_q;
    acc_sum  = acc_base + prod_ext;
    ovf_now  = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      3'd0:    rdata = 32'(opa_q);
      3'd1:    rdata = 32'(opb_q);
      3'd2:    rdata = {29'd0, acc_en_q, 2'b00};
      3'd3:    rdata = {29'd0, ovf_q, done_q, busy};
      3'd4:    rdata = 32'(product_q);
      3'd5:    rdata = 32'(acc_q);
      default: rdata = 32'd0;
    endcase
  end

  assign apb.PREADY  = access;
  assign apb.PSLVERR = access & err;
  assign apb.PRDATA  = (access && !apb.PWRITE && !err) ? rdata : 32'd0;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_en_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_start <= 1'b0;
      if (wr_opa)  opa_q    <= apb.PWDATA[OPERAND_WIDTH-1:0];
      if (wr_opb)  opb_q    <= apb.PWDATA[OPERAND_WIDTH-1:0];
      if (wr_ctrl) acc_en_q <= apb.PWDATA[2];
      if (acc_clr) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
      if (wr_status) begin
        if (apb.PWDATA[1]) done_q <= 1'b0;
        if (apb.PWDATA[2]) ovf_q  <= 1'b0;
      end
      // FSM updates come last so a flag set in ACCUM beats a same-cycle W1C.
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StLaunch;
            mul_start <= 1'b1;
            mul_a     <= opa_q;
            mul_b     <= opb_q;
          end
        end
        StLaunch: state_q <= StWait;
        StWait: begin
          if (BOOTH_READY) begin
            product_q <= BOOTH_OUTPUT;
            state_q   <= StAccum;
          end
        end
        StAccum: begin
          acc_q   <= acc_sum;
          done_q  <= 1'b1;
          if (ovf_now) ovf_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_booth_mac_slave.sv
// Directed bench: a 32-bit accumulator slave at base 0x0 and a 16-bit one at base 0x100, each
// driven by a small Booth core model that answers mul_start six cycles later.
module tb_apb_booth_mac_slave;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [1:0]  b_sel = 2'b00;
  logic        b_en = 1'b0, b_wr = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;

  logic [1:0]  ms;
  logic [7:0]  ma [2];
  logic [7:0]  mb [2];
  logic [1:0]  bready;
  logic [15:0] bout [2];

  logic        model_en0 = 1'b1;
  logic        man_ready0 = 1'b0;
  logic [15:0] man_out0 = '0;
  logic [1:0]  m_ready = 2'b00;
  int          m_cnt [2] = '{0, 0};
  logic [15:0] m_prod [2];
  int          start_cnt [2] = '{0, 0};

  int n_pass = 0;
  int n_chk  = 0;

  always #5 pclk = ~pclk;

  apb_booth_mac_slave_if ifc0();
  apb_booth_mac_slave_if ifc1();

  assign ifc0.PSELx   = b_sel[0];
  assign ifc1.PSELx   = b_sel[1];
  assign ifc0.PENABLE = b_en;
  assign ifc1.PENABLE = b_en;
  assign ifc0.PWRITE  = b_wr;
  assign ifc1.PWRITE  = b_wr;
  assign ifc0.PADDR   = b_addr;
  assign ifc1.PADDR   = b_addr;
  assign ifc0.PWDATA  = b_wdata;
  assign ifc1.PWDATA  = b_wdata;

  assign bready[0] = model_en0 ? m_ready[0] : man_ready0;
  assign bout[0]   = model_en0 ? m_prod[0]  : man_out0;
  assign bready[1] = m_ready[1];
  assign bout[1]   = m_prod[1];

  apb_booth_mac_slave #(.OPERAND_WIDTH(8), .ACC_WIDTH(32), .SLAVE_BASE(32'h0)) dut0 (
    .PCLK(pclk), .PRESETn(presetn), .apb(ifc0), .mul_start(ms[0]), .mul_a(ma[0]),
    .mul_b(mb[0]), .BOOTH_READY(bready[0]), .BOOTH_OUTPUT(bout[0])
  );

  apb_booth_mac_slave #(.OPERAND_WIDTH(8), .ACC_WIDTH(16), .SLAVE_BASE(32'h100)) dut1 (
    .PCLK(pclk), .PRESETn(presetn), .apb(ifc1), .mul_start(ms[1]), .mul_a(ma[1]),
    .mul_b(mb[1]), .BOOTH_READY(bready[1]), .BOOTH_OUTPUT(bout[1])
  );

  // Booth core model: signed 8x8 product, ready pulse six cycles after mul_start.
  always @(posedge pclk) begin
    for (int i = 0; i < 2; i++) begin
      m_ready[i] <= 1'b0;
      if (ms[i]) begin
        start_cnt[i] <= start_cnt[i] + 1;
        m_cnt[i]     <= 6;
        m_prod[i]    <= {{8{ma[i][7]}}, ma[i]} * {{8{mb[i][7]}}, mb[i]};
      end else if (m_cnt[i] != 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        if (m_cnt[i] == 1) m_ready[i] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic apb(input int inst, input bit wr, input logic [31:0] off,
                     input logic [31:0] wd, output logic [31:0] rd, output logic err);
    @(posedge pclk); #1;
    b_addr  = (inst == 1 ? 32'h100 : 32'h0) + off;
    b_wr    = wr;
    b_wdata = wd;
    b_sel   = (inst == 1) ? 2'b10 : 2'b01;
    b_en    = 1'b0;
    @(posedge pclk); #1;
    b_en = 1'b1;
    #3;
    rd  = (inst == 1) ? ifc1.PRDATA  : ifc0.PRDATA;
    err = (inst == 1) ? ifc1.PSLVERR : ifc0.PSLVERR;
    check("pready", {31'd0, (inst == 1) ? ifc1.PREADY : ifc0.PREADY}, 32'd1);
    @(posedge pclk); #1;
    b_sel = 2'b00;
    b_en  = 1'b0;
  endtask

  task automatic wr_reg(input int inst, input logic [31:0] off, input logic [31:0] wd,
                        input bit exp_err, input string tag);
    logic [31:0] rd;
    logic        err;
    apb(inst, 1'b1, off, wd, rd, err);
    check(tag, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic rd_reg(input int inst, input logic [31:0] off, input logic [31:0] exp,
                        input string tag);
    logic [31:0] rd;
    logic        err;
    apb(inst, 1'b0, off, 32'd0, rd, err);
    check(tag, rd, exp);
  endtask

  task automatic wait_idle(input int inst);
    logic [31:0] rd;
    logic        err;
    rd = 32'd1;
    for (int i = 0; i < 40 && rd[0]; i++) apb(inst, 1'b0, 32'h0C, 32'd0, rd, err);
    check("busy_timeout", {31'd0, rd[0]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          st0;

    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    #1;
    check("pready_idle", {31'd0, ifc0.PREADY}, 32'd0);
    check("reset_mul_start", {31'd0, ms[0]}, 32'd0);
    rd_reg(0, 32'h0C, 32'h0, "reset_status");
    rd_reg(0, 32'h14, 32'h0, "reset_acc");
    rd_reg(0, 32'h10, 32'h0, "reset_product");
    rd_reg(0, 32'h08, 32'h0, "reset_ctrl");

    // 5 * -3 with accumulation disabled
    wr_reg(0, 32'h00, 32'h05, 1'b0, "wr_opa");
    wr_reg(0, 32'h04, 32'hFD, 1'b0, "wr_opb");
    wr_reg(0, 32'h08, 32'h1, 1'b0, "wr_start");
    wait_idle(0);
    rd_reg(0, 32'h10, 32'hFFFF_FFF1, "product_neg");
    rd_reg(0, 32'h14, 32'hFFFF_FFF1, "acc_neg");
    rd_reg(0, 32'h0C, 32'h2, "status_done");
    rd_reg(0, 32'h04, 32'hFD, "opb_readback");
    wr_reg(0, 32'h0C, 32'h2, 1'b0, "w1c_done");
    rd_reg(0, 32'h0C, 32'h0, "status_cleared");

    // Clear and enable, then three 0x7F * 0x7F accumulations
    wr_reg(0, 32'h00, 32'h7F, 1'b0, "wr_opa_7f");
    wr_reg(0, 32'h04, 32'h7F, 1'b0, "wr_opb_7f");
    wr_reg(0, 32'h08, 32'h6, 1'b0, "clr_en");
    rd_reg(0, 32'h14, 32'h0, "acc_cleared");
    for (int k = 0; k < 3; k++) begin
      wr_reg(0, 32'h08, 32'h5, 1'b0, "wr_start_acc");
      wait_idle(0);
    end
    rd_reg(0, 32'h14, 32'h0000_BD03, "acc_3x");
    rd_reg(0, 32'h10, 32'h0000_3F01, "product_pos");
    rd_reg(0, 32'h0C, 32'h2, "status_no_ovf");
    rd_reg(0, 32'h08, 32'h4, "ctrl_readback");

    // Writes while busy are rejected
    st0 = start_cnt[0];
    wr_reg(0, 32'h08, 32'h5, 1'b0, "start_busy_run");
    wr_reg(0, 32'h00, 32'h11, 1'b1, "opa_while_busy");
    wr_reg(0, 32'h08, 32'h1, 1'b1, "start_while_busy");
    wait_idle(0);
    rd_reg(0, 32'h00, 32'h7F, "opa_unchanged");
    check("single_start", start_cnt[0] - st0, 32'd1);
    rd_reg(0, 32'h14, 32'h0000_FC04, "acc_4x");

    // Address errors
    apb(0, 1'b0, 32'h18, 32'd0, rd, err);
    check("rd_unmapped_err", {31'd0, err}, 32'd1);
    wr_reg(0, 32'h14, 32'h1, 1'b1, "wr_acc_err");
    apb(0, 1'b0, 32'h02, 32'd0, rd, err);
    check("rd_misaligned_err", {31'd0, err}, 32'd1);
    apb(0, 1'b0, 32'h10, 32'd0, rd, err);
    check("rd_product_ok", {31'd0, err}, 32'd0);

    // 16-bit accumulator: 0x4000 + 0x3F01 + 0x3F01 wraps to 0xBE02 with overflow
    wr_reg(1, 32'h00, 32'h80, 1'b0, "w16_opa");
    wr_reg(1, 32'h04, 32'h80, 1'b0, "w16_opb");
    wr_reg(1, 32'h08, 32'h6, 1'b0, "w16_clr_en");
    wr_reg(1, 32'h08, 32'h5, 1'b0, "w16_start1");
    wait_idle(1);
    rd_reg(1, 32'h14, 32'h0000_4000, "w16_acc1");
    wr_reg(1, 32'h00, 32'h7F, 1'b0, "w16_opa2");
    wr_reg(1, 32'h04, 32'h7F, 1'b0, "w16_opb2");
    wr_reg(1, 32'h08, 32'h5, 1'b0, "w16_start2");
    wait_idle(1);
    rd_reg(1, 32'h14, 32'h0000_7F01, "w16_acc2");
    rd_reg(1, 32'h0C, 32'h2, "w16_no_ovf");
    wr_reg(1, 32'h08, 32'h5, 1'b0, "w16_start3");
    wait_idle(1);
    rd_reg(1, 32'h14, 32'hFFFF_BE02, "w16_acc_wrap");
    rd_reg(1, 32'h0C, 32'h6, "w16_ovf");
    wr_reg(1, 32'h08, 32'h2, 1'b0, "w16_clr");
    rd_reg(1, 32'h14, 32'h0, "w16_acc_zero");
    rd_reg(1, 32'h0C, 32'h2, "w16_ovf_cleared");

    // Reset while waiting on the core; a late ready must be ignored
    model_en0 = 1'b0;
    wr_reg(0, 32'h08, 32'h1, 1'b0, "rst_start");
    check("launch_pulse", {31'd0, ms[0]}, 32'd1);
    @(posedge pclk); #1;
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn    = 1'b1;
    st0        = start_cnt[0];
    man_ready0 = 1'b1;
    man_out0   = 16'h1234;
    @(posedge pclk); #1;
    man_ready0 = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_no_mul_start", start_cnt[0] - st0, 32'd0);
    rd_reg(0, 32'h14, 32'h0, "rst_acc");
    rd_reg(0, 32'h10, 32'h0, "rst_product");
    rd_reg(0, 32'h0C, 32'h0, "rst_status");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
